// File: rtl/divider_8bit_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : divider_8bit_seq_if
// Brief    : Start/busy/done handshake and operand/result bus for the divider.
// Revision : 1.0 - initial release
// ============================================================================
interface divider_8bit_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/divider_8bit_seq.sv
`default_nettype none
// ============================================================================
// Module   : divider_8bit_seq
// Brief    : Sequential restoring unsigned divider, one quotient bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module divider_8bit_seq #(
    parameter int WIDTH = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    divider_8bit_seq_if.slave bus
);

    localparam int              CNT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CALC = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;

    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_done;
    logic             r_div_by_zero;

    logic             w_divisor_zero;
    logic             w_accept;
    logic             w_zero_accept;
    logic             w_iterate;
    logic             w_finish;
    logic             w_busy;

    logic [WIDTH:0]   w_shift_rem;
    logic [WIDTH+1:0] w_trial;
    logic             w_borrow;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    assign w_divisor_zero = (bus.divisor == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !w_divisor_zero) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (r_count == c_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_accept      = 1'b0;
        w_zero_accept = 1'b0;
        w_iterate     = 1'b0;
        w_finish      = 1'b0;
        w_busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept      = bus.start && !w_divisor_zero;
                w_zero_accept = bus.start &&  w_divisor_zero;
            end
            S_CALC: begin
                w_busy    = 1'b1;
                w_iterate = 1'b1;
                w_finish  = (r_count == c_last);
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // The shifted remainder can reach WIDTH+1 bits when the divisor has its
    // MSB set, so the subtract carries one extra bit to keep the borrow exact.
    assign w_shift_rem = {r_rem, r_quo[WIDTH-1]};
    assign w_trial     = {1'b0, w_shift_rem} + ~{2'b00, r_divisor} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign w_borrow    = w_trial[WIDTH+1];
    assign w_rem_nxt   = w_borrow ? w_shift_rem[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_nxt   = {r_quo[WIDTH-2:0], ~w_borrow};

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_divisor     <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_count       <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_divisor     <= bus.divisor;
                r_rem         <= '0;
                r_quo         <= bus.dividend;
                r_count       <= '0;
                r_div_by_zero <= 1'b0;
            end else if (w_zero_accept) begin
                r_quotient    <= '1;
                r_remainder   <= bus.dividend;
                r_div_by_zero <= 1'b1;
                r_done        <= 1'b1;
            end else if (w_iterate) begin
                r_rem   <= w_rem_nxt;
                r_quo   <= w_quo_nxt;
                r_count <= r_count + CNT_W'(1);
                if (w_finish) begin
                    r_quotient  <= w_quo_nxt;
                    r_remainder <= w_rem_nxt;
                    r_done      <= 1'b1;
                end
            end
        end
    end

    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.busy        = w_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_divider_8bit_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_8bit_seq
// Brief    : Directed self-checking bench for divider_8bit_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider_8bit_seq;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    divider_8bit_seq_if #(.WIDTH(WIDTH)) bus_if ();

    divider_8bit_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for exactly one edge; returns just after that edge.
    task automatic issue(input logic [7:0] dd, input logic [7:0] dv);
        bus_if.start    = 1'b1;
        bus_if.dividend = dd;
        bus_if.divisor  = dv;
        tick();
        bus_if.start    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.start = 1'b0;
        bus_if.dividend = '0;
        bus_if.divisor = '0;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus_if.quotient !== 8'd0) begin
            n_errors++; $display("FAIL reset_quotient got=%0d exp=0", bus_if.quotient);
        end
        n_checks++;
        if (bus_if.remainder !== 8'd0) begin
            n_errors++; $display("FAIL reset_remainder got=%0d exp=0", bus_if.remainder);
        end
        n_checks++;
        if ({bus_if.busy, bus_if.done, bus_if.div_by_zero} !== 3'b000) begin
            n_errors++; $display("FAIL reset_flags got busy/done/dbz=%b exp=000",
                                 {bus_if.busy, bus_if.done, bus_if.div_by_zero});
        end
    endtask

    task automatic test_basic();
        issue(8'd200, 8'd7);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0 || bus_if.quotient !== 8'd0) begin
                n_errors++; $display("FAIL basic_busy edge N+%0d busy=%b done=%b q=%0d exp busy=1 done=0 q=0",
                                     k, bus_if.busy, bus_if.done, bus_if.quotient);
            end
            if (k < 7) tick();
        end
        tick();
        n_checks++;
        if (bus_if.done !== 1'b1 || bus_if.busy !== 1'b0) begin
            n_errors++; $display("FAIL basic_done_edge8 done=%b busy=%b exp done=1 busy=0",
                                 bus_if.done, bus_if.busy);
        end
        n_checks++;
        if (bus_if.quotient !== 8'd28 || bus_if.remainder !== 8'd4 || bus_if.div_by_zero !== 1'b0) begin
            n_errors++; $display("FAIL basic_result q=%0d r=%0d dbz=%b exp q=28 r=4 dbz=0",
                                 bus_if.quotient, bus_if.remainder, bus_if.div_by_zero);
        end
        tick();
        n_checks++;
        if (bus_if.done !== 1'b0 || bus_if.quotient !== 8'd28) begin
            n_errors++; $display("FAIL basic_done_pulse done=%b q=%0d exp done=0 q=28",
                                 bus_if.done, bus_if.quotient);
        end
    endtask

    task automatic test_patterns();
        logic [7:0] v_dd [3] = '{8'd255, 8'd5, 8'd255};
        logic [7:0] v_dv [3] = '{8'd1,   8'd9, 8'd255};
        logic [7:0] v_q  [3] = '{8'd255, 8'd0, 8'd1};
        logic [7:0] v_r  [3] = '{8'd0,   8'd5, 8'd0};
        for (int i = 0; i < 3; i++) begin
            int lat;
            issue(v_dd[i], v_dv[i]);
            lat = 0;
            while (bus_if.done !== 1'b1 && lat < 20) begin
                tick();
                lat++;
            end
            n_checks++;
            if (lat !== 8) begin
                n_errors++; $display("FAIL pattern%0d_latency got=%0d exp=8", i, lat);
            end
            n_checks++;
            if (bus_if.quotient !== v_q[i] || bus_if.remainder !== v_r[i]) begin
                n_errors++; $display("FAIL pattern%0d_result q=%0d r=%0d exp q=%0d r=%0d",
                                     i, bus_if.quotient, bus_if.remainder, v_q[i], v_r[i]);
            end
            tick();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        issue(8'd37, 8'd0);
        n_checks++;
        if (bus_if.done !== 1'b1 || bus_if.div_by_zero !== 1'b1 || bus_if.busy !== 1'b0) begin
            n_errors++; $display("FAIL dbz_flags done=%b dbz=%b busy=%b exp 1 1 0",
                                 bus_if.done, bus_if.div_by_zero, bus_if.busy);
        end
        n_checks++;
        if (bus_if.quotient !== 8'hFF || bus_if.remainder !== 8'd37) begin
            n_errors++; $display("FAIL dbz_result q=%0h r=%0d exp q=ff r=37",
                                 bus_if.quotient, bus_if.remainder);
        end
        tick();
        n_checks++;
        if (bus_if.done !== 1'b0 || bus_if.div_by_zero !== 1'b1 || bus_if.busy !== 1'b0) begin
            n_errors++; $display("FAIL dbz_hold done=%b dbz=%b busy=%b exp 0 1 0",
                                 bus_if.done, bus_if.div_by_zero, bus_if.busy);
        end
        issue(8'd10, 8'd3);
        n_checks++;
        if (bus_if.div_by_zero !== 1'b0 || bus_if.busy !== 1'b1) begin
            n_errors++; $display("FAIL dbz_clear dbz=%b busy=%b exp dbz=0 busy=1",
                                 bus_if.div_by_zero, bus_if.busy);
        end
        lat = 0;
        while (bus_if.done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== 8 || bus_if.quotient !== 8'd3 || bus_if.remainder !== 8'd1) begin
            n_errors++; $display("FAIL dbz_next lat=%0d q=%0d r=%0d exp lat=8 q=3 r=1",
                                 lat, bus_if.quotient, bus_if.remainder);
        end
        tick();
    endtask

    task automatic test_busy_ignore();
        int done_cnt;
        int done_edge;
        logic [7:0] q_at;
        logic [7:0] r_at;
        done_cnt = 0;
        done_edge = -1;
        q_at = '0;
        r_at = '0;
        issue(8'd100, 8'd10);
        for (int e = 1; e <= 16; e++) begin
            if (e == 3) begin
                bus_if.start = 1'b1;
                bus_if.dividend = 8'd50;
                bus_if.divisor = 8'd5;
            end
            tick();
            bus_if.start = 1'b0;
            if (bus_if.done === 1'b1) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = e;
                    q_at = bus_if.quotient;
                    r_at = bus_if.remainder;
                end
            end
        end
        n_checks++;
        if (done_cnt !== 1 || done_edge !== 8) begin
            n_errors++; $display("FAIL busy_ignore_done count=%0d edge=%0d exp count=1 edge=8",
                                 done_cnt, done_edge);
        end
        n_checks++;
        if (q_at !== 8'd10 || r_at !== 8'd0) begin
            n_errors++; $display("FAIL busy_ignore_result q=%0d r=%0d exp q=10 r=0", q_at, r_at);
        end
    endtask

    task automatic test_abort();
        int done_cnt;
        int lat;
        issue(8'd200, 8'd7);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus_if.quotient !== 8'd0 || bus_if.remainder !== 8'd0 ||
            {bus_if.busy, bus_if.done, bus_if.div_by_zero} !== 3'b000) begin
            n_errors++; $display("FAIL abort_state q=%0d r=%0d busy/done/dbz=%b exp 0 0 000",
                                 bus_if.quotient, bus_if.remainder,
                                 {bus_if.busy, bus_if.done, bus_if.div_by_zero});
        end
        done_cnt = 0;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) done_cnt++;
        end
        n_checks++;
        if (done_cnt !== 0) begin
            n_errors++; $display("FAIL abort_no_done activity=%0d exp=0", done_cnt);
        end
        issue(8'd9, 8'd2);
        lat = 0;
        while (bus_if.done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== 8 || bus_if.quotient !== 8'd4 || bus_if.remainder !== 8'd1) begin
            n_errors++; $display("FAIL abort_fresh lat=%0d q=%0d r=%0d exp lat=8 q=4 r=1",
                                 lat, bus_if.quotient, bus_if.remainder);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(8'd17, 8'd4);
        for (int e = 1; e <= 7; e++) tick();
        // Request held from before the completing edge through the done cycle.
        bus_if.start = 1'b1;
        bus_if.dividend = 8'd64;
        bus_if.divisor = 8'd8;
        tick();
        n_checks++;
        if (bus_if.done !== 1'b1 || bus_if.quotient !== 8'd4 || bus_if.remainder !== 8'd1) begin
            n_errors++; $display("FAIL b2b_first done=%b q=%0d r=%0d exp done=1 q=4 r=1",
                                 bus_if.done, bus_if.quotient, bus_if.remainder);
        end
        tick();
        bus_if.start = 1'b0;
        n_checks++;
        if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0) begin
            n_errors++; $display("FAIL b2b_accept busy=%b done=%b exp busy=1 done=0",
                                 bus_if.busy, bus_if.done);
        end
        lat = 0;
        while (bus_if.done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== 8 || bus_if.quotient !== 8'd8 || bus_if.remainder !== 8'd0) begin
            n_errors++; $display("FAIL b2b_second lat=%0d q=%0d r=%0d exp lat=8 q=8 r=0",
                                 lat, bus_if.quotient, bus_if.remainder);
        end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_basic();
        test_patterns();
        test_div_zero();
        test_busy_ignore();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/divider_8bit_seq.md
Name: divider_8bit_seq

Overview:
- Sequential restoring divider that sits directly downstream of the 8-bit subtractor datapath.
- Divides an unsigned dividend by an unsigned divisor, one quotient bit per clock, using a trial subtraction each cycle.
- Produces quotient, remainder, and a divide-by-zero flag.
- Uses a start/busy/done handshake so a controller or FSM can issue divisions and collect results.

Parameters:
- WIDTH, 8, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only while busy=0.
- dividend  input  WIDTH  unsigned dividend; captured when start is accepted.
- divisor  input  WIDTH  unsigned divisor; captured when start is accepted.
- quotient  output  WIDTH  registered quotient result.
- remainder  output  WIDTH  registered remainder result.
- busy  output  1  high while an iteration sequence is running.
- done  output  1  one-cycle pulse when the result is valid.
- div_by_zero  output  1  set with done when divisor was 0; held until the next accepted start.

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, state=IDLE, iteration counter=0.
- rst has priority over every other input in every state. Asserting it mid-division aborts the operation; no done pulse is produced.
- States: IDLE and CALC only.
- IDLE, start=1, divisor≠0 (edge N):
  - Latch the divisor.
  - Load the working register {rem, quo} = {0, dividend}.
  - Set counter=0, busy=1, div_by_zero=0; go to CALC.
- IDLE, start=1, divisor=0 (edge N):
  - Stay in IDLE.
  - quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1, done=1 after edge N.
  - Latency: 1 edge.
- CALC, each edge:
  - Shift {rem, quo} left by 1.
  - Compute the trial difference at WIDTH+1 bits: shifted_rem + ~{0,divisor} + 1 (two's-complement subtract).
  - If the trial MSB is 0 (no borrow): rem=trial[WIDTH-1:0] and quo[0]=1. Otherwise rem keeps the shifted value and quo[0]=0.
  - Increment the counter.
- Completion: on the edge completing iteration WIDTH (edge N+WIDTH):
  - Transfer quo→quotient and rem→remainder.
  - busy=0, done=1; return to IDLE.
  - Latency: WIDTH edges from accept to done (8 by default).
- done is high for exactly one cycle, then cleared.
- quotient, remainder, and div_by_zero hold their values until the next accepted start or rst.
- While busy=1: start is ignored, and changes on dividend/divisor have no effect.
- Back-to-back: start=1 in the cycle where done=1 (state IDLE) is accepted; the new result overwrites the old one WIDTH edges later.
- quotient/remainder change only at completion or at a divide-by-zero accept. During CALC they keep the previous result.
- The remainder always satisfies remainder < divisor. Unsigned only; no overflow cases exist other than divide-by-zero.

Test Plan:
- After rst, dividend=200, divisor=7, start pulse at edge N:
  - busy=1 for edges N..N+7.
  - done=1 after edge N+8 with quotient=28, remainder=4, div_by_zero=0.
  - done=0 after edge N+9.
- 255/1 → quotient=255, remainder=0. Then 5/9 → quotient=0, remainder=5. Then 255/255 → quotient=1, remainder=0. Each result arrives 8 edges after accept.
- 37/0 → after 1 edge: done=1, div_by_zero=1, quotient=8'hFF, remainder=37, busy never asserted. The next valid start (e.g. 10/3) clears div_by_zero and yields quotient=3, remainder=1.
- 100/10 started, then start=1 with 50/5 pulsed at edge N+3 while busy:
  - The second request is ignored.
  - done after edge N+8 with quotient=10, remainder=0.
  - Exactly one done pulse.
- 200/7 started, rst=1 at edge N+4:
  - All outputs return to 0 and busy=0.
  - No done pulse follows.
  - A fresh 9/2 start then gives quotient=4, remainder=1.
- Back-to-back: start 17/4, then hold start=1 with 64/8 during the done cycle:
  - First result quotient=4, remainder=1.
  - Second result accepted immediately, completing 8 edges later with quotient=8, remainder=0.
